// File: rtl/tt_pkg.sv
// Shared types and width helpers for the truth-table capture block.
package tt_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } ttState_e;

  // Ceiling log2 with a floor of one bit so a counter always has a width.
  function automatic int ttClog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

  // Number of truth-table bits for an n-input function.
  function automatic int ttWidth(input int nIn);
    return 1 << nIn;
  endfunction

  // Highest input combination index for an n-input function.
  function automatic int ttIdxLast(input int nIn);
    return (1 << nIn) - 1;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle timer: counts the cycles an input combination has been held and
// flags the last settle cycle so the controller can move to sampling.
module tt_settle_timer
  import tt_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = ttClog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  logic [CNT_W-1:0] r_count;

  // Restart from zero on each new combination, otherwise count up while settling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == CNT_LAST);

endmodule

// File: rtl/truth_table_capture.sv
// Truth-table capture: sweeps every input combination of an N_IN-input
// function, waits SETTLE_CYC cycles per combination, samples the output and
// packs the result so bit i holds the output seen while dut_in == i.
module truth_table_capture
  import tt_pkg::*;
#(
  parameter int N_IN       = 3,
  parameter int SETTLE_CYC = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  output logic [N_IN-1:0]            dut_in,
  input  logic                       dut_out,
  output logic                       busy,
  output logic                       done,
  output logic                       tt_valid,
  output logic [ttWidth(N_IN)-1:0]   truth_table
);

  localparam int TT_W = ttWidth(N_IN);
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(ttIdxLast(N_IN));

  ttState_e r_state;
  ttState_e w_stateNext;

  logic [N_IN-1:0] r_idx;
  logic [N_IN-1:0] r_dutIn;
  logic            r_busy;
  logic            r_done;
  logic            r_ttValid;
  logic [TT_W-1:0] r_truthTable;

  logic w_startOk;
  logic w_lastIdx;
  logic w_timerLoad;
  logic w_timerEnable;
  logic w_timerExpired;

  assign w_startOk     = start && !abort;
  assign w_lastIdx     = (r_idx == IDX_LAST);
  assign w_timerLoad   = (w_stateNext == ST_SETTLE) && (r_state != ST_SETTLE);
  assign w_timerEnable = (r_state == ST_SETTLE);

  tt_settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settleTimer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_timerLoad),
    .i_enable  (w_timerEnable),
    .o_expired (w_timerExpired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode; abort wins over progress while a sweep is running.
  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_startOk) begin
          w_stateNext = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          w_stateNext = ST_IDLE;
        end else if (w_timerExpired) begin
          w_stateNext = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          w_stateNext = ST_IDLE;
        end else if (w_lastIdx) begin
          w_stateNext = ST_DONE;
        end else begin
          w_stateNext = ST_SETTLE;
        end
      end
      ST_DONE: begin
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Sweep datapath: index, driven input, captured table and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_dutIn      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ttValid    <= 1'b0;
      r_truthTable <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_startOk) begin
            r_idx        <= '0;
            r_dutIn      <= '0;
            r_ttValid    <= 1'b0;
            r_truthTable <= '0;
            r_busy       <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_dutIn <= '0;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_dutIn <= '0;
          end else begin
            r_truthTable[r_idx] <= dut_out;
            if (w_lastIdx) begin
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_ttValid <= 1'b1;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_dutIn <= r_idx + 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_dutIn <= '0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign dut_in      = r_dutIn;
  assign busy        = r_busy;
  assign done        = r_done;
  assign tt_valid    = r_ttValid;
  assign truth_table = r_truthTable;

endmodule
